// File: rtl/fpu_pcpi_sequencer.sv
// PCPI front end for a shared multi-cycle FP unit: decodes OP-FP add/sub/mul, issues one request, returns the result.
// Optional accrued-flag register enabled by defining FPU_FFLAGS_EN.
module fpu_pcpi_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned OPW            = 2
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           pcpi_valid,
    input  logic [31:0]    pcpi_insn,
    input  logic [31:0]    pcpi_rs1,
    input  logic [31:0]    pcpi_rs2,
    output logic           pcpi_wr,
    output logic [31:0]    pcpi_rd,
    output logic           pcpi_wait,
    output logic           pcpi_ready,
    output logic           fpu_req_valid,
    input  logic           fpu_req_ready,
    output logic [OPW-1:0] fpu_op,
    output logic [31:0]    fpu_a,
    output logic [31:0]    fpu_b,
    input  logic           fpu_rsp_valid,
    input  logic [31:0]    fpu_rsp_data,
    input  logic [4:0]     fpu_rsp_flags,
    output logic [4:0]     fflags,
    input  logic           fflags_clr
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t         state, state_nxt;
    logic           hit;
    logic [OPW-1:0] dec_op;
    logic [CW-1:0]  cnt;
    logic           timeout;
    logic [31:0]    result;

    always_comb begin
        hit    = 1'b0;
        dec_op = '0;
        if (pcpi_insn[6:0] == 7'b1010011) begin
            case (pcpi_insn[31:25])
                7'b0000000: begin hit = 1'b1; dec_op = OPW'(0); end
                7'b0000100: begin hit = 1'b1; dec_op = OPW'(1); end
                7'b0001000: begin hit = 1'b1; dec_op = OPW'(2); end
                default:    begin hit = 1'b0; dec_op = '0;      end
            endcase
        end
    end

    // cnt counts completed cycles in WAIT/DRAIN; the last permitted cycle is TIMEOUT_CYCLES-1
    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pcpi_valid && hit) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (!pcpi_valid)        state_nxt = S_IDLE;
                else if (fpu_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!pcpi_valid)                  state_nxt = (fpu_rsp_valid || timeout) ? S_IDLE : S_DRAIN;
                else if (fpu_rsp_valid || timeout) state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_HOLD;
            S_HOLD:  state_nxt = S_IDLE;
            S_DRAIN: if (fpu_rsp_valid || timeout) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            fpu_op <= '0;
            fpu_a  <= '0;
            fpu_b  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == S_WAIT || state == S_DRAIN) ? cnt + CW'(1) : '0;
            if (state == S_IDLE && pcpi_valid && hit) begin
                fpu_op <= dec_op;
                fpu_a  <= pcpi_rs1;
                fpu_b  <= pcpi_rs2;
            end
        end
    end

`ifdef FPU_FFLAGS_EN
    logic [4:0] res_flags;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result    <= '0;
            res_flags <= '0;
            fflags    <= '0;
        end else begin
            if (state == S_WAIT) begin
                if (fpu_rsp_valid) begin
                    result    <= fpu_rsp_data;
                    res_flags <= fpu_rsp_flags;
                end else if (timeout) begin
                    result    <= 32'h7FC0_0000;
                    res_flags <= 5'b10000;
                end
            end
            // clear takes priority, so a result completing in the clear cycle is not accrued
            if (fflags_clr)
                fflags <= '0;
            else if (state == S_RESP)
                fflags <= fflags | res_flags;
        end
    end
`else
    logic unused_flag_inputs;

    assign unused_flag_inputs = ^{fflags_clr, fpu_rsp_flags};
    assign fflags             = '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result <= '0;
        end else if (state == S_WAIT) begin
            if (fpu_rsp_valid)
                result <= fpu_rsp_data;
            else if (timeout)
                result <= 32'h7FC0_0000;
        end
    end
`endif

    assign fpu_req_valid = (state == S_ISSUE);
    assign pcpi_wait     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_RESP);
    assign pcpi_ready    = (state == S_RESP);
    assign pcpi_wr       = (state == S_RESP);
    assign pcpi_rd       = (state == S_RESP) ? result : '0;

endmodule

// File: tb/tb_fpu_pcpi_sequencer.sv
// Directed self-checking bench for fpu_pcpi_sequencer; FPU_FFLAGS_EN selects the expected fflags values.
module tb_fpu_pcpi_sequencer;

    localparam int unsigned TO = 64;
`ifdef FPU_FFLAGS_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    localparam logic [31:0] I_FMUL = 32'h1031_0253;
    localparam logic [31:0] I_FADD = 32'h0031_0253;
    localparam logic [31:0] I_FSUB = 32'h0831_0253;
    localparam logic [31:0] I_MUL  = 32'h0220_8033;
    localparam logic [31:0] I_FADDD = 32'h0231_0253;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;
    logic        fpu_req_valid, fpu_req_ready;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_rsp_valid;
    logic [31:0] fpu_rsp_data;
    logic [4:0]  fpu_rsp_flags;
    logic [4:0]  fflags;
    logic        fflags_clr;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fpu_pcpi_sequencer #(.TIMEOUT_CYCLES(TO), .OPW(2)) dut (
        .clk(clk), .resetn(resetn),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .fpu_req_valid(fpu_req_valid), .fpu_req_ready(fpu_req_ready), .fpu_op(fpu_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_rsp_valid(fpu_rsp_valid), .fpu_rsp_data(fpu_rsp_data), .fpu_rsp_flags(fpu_rsp_flags),
        .fflags(fflags), .fflags_clr(fflags_clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction to completion with a small FP-unit model: request accepted after
    // rdy_delay cycles, response strobed lat cycles after the handshake (lat=0: never).
    task automatic run_op(input string tag, input logic [31:0] insn, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] op, input int rdy_delay,
                          input int lat, input logic [31:0] rsp, input logic [4:0] flg,
                          input logic [31:0] exp_rd, input int exp_delta);
        int cyc, req_cycles, hs_cyc, ready_cyc, extra;
        logic [31:0] rd_seen;
        logic wr_seen, wait_seen, wait_ok, stable_ok, hs;
        cyc = 0; req_cycles = 0; hs_cyc = -1000; ready_cyc = -1; extra = 0;
        rd_seen = '0; wr_seen = 1'b0; wait_seen = 1'b0; wait_ok = 1'b1; stable_ok = 1'b1; hs = 1'b0;
        pcpi_valid = 1'b1; pcpi_insn = insn; pcpi_rs1 = a; pcpi_rs2 = b;
        fpu_rsp_data = rsp; fpu_rsp_flags = flg;
        while (ready_cyc < 0 && cyc < 300) begin
            if (pcpi_ready) begin
                ready_cyc = cyc; rd_seen = pcpi_rd; wr_seen = pcpi_wr; wait_seen = pcpi_wait;
            end else begin
                if (cyc >= 1 && !pcpi_wait) wait_ok = 1'b0;
                if (fpu_req_valid) begin
                    if (hs) extra++;
                    if (fpu_a !== a || fpu_b !== b || fpu_op !== op) stable_ok = 1'b0;
                    fpu_req_ready = (req_cycles >= rdy_delay);
                    req_cycles++;
                    if (fpu_req_ready) begin hs = 1'b1; hs_cyc = cyc; end
                end else begin
                    fpu_req_ready = 1'b0;
                end
                fpu_rsp_valid = (lat > 0 && cyc == hs_cyc + lat);
                step();
                cyc++;
            end
        end
        fpu_rsp_valid = 1'b0;
        fpu_req_ready = 1'b0;
        check({tag, " ready seen"}, 64'(ready_cyc >= 0), 64'd1);
        check({tag, " rd"}, 64'(rd_seen), 64'(exp_rd));
        check({tag, " wr"}, 64'(wr_seen), 64'd1);
        check({tag, " wait at ready"}, 64'(wait_seen), 64'd1);
        check({tag, " wait held"}, 64'(wait_ok), 64'd1);
        check({tag, " operands stable"}, 64'(stable_ok), 64'd1);
        check({tag, " extra requests"}, 64'(extra), 64'd0);
        check({tag, " latency"}, 64'(ready_cyc - hs_cyc - 1), 64'(exp_delta));
        pcpi_valid = 1'b0;
        step();
        check({tag, " rd/wr cleared"}, {31'd0, pcpi_ready, pcpi_wr, pcpi_rd}, 64'd0);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            if (pcpi_ready) extra++;
            step();
        end
        check({tag, " single ready"}, 64'(extra), 64'd0);
    endtask

    // Brings a fmul.s into WAIT (handshake done, no response yet).
    task automatic enter_wait(input string tag);
        int n;
        n = 0;
        pcpi_valid = 1'b1; pcpi_insn = I_FMUL; pcpi_rs1 = 32'h4040_0000; pcpi_rs2 = 32'h4040_0000;
        while (!fpu_req_valid && n < 10) begin step(); n++; end
        check({tag, " request raised"}, 64'(fpu_req_valid), 64'd1);
        fpu_req_ready = 1'b1;
        step();
        fpu_req_ready = 1'b0;
    endtask

    initial begin
        logic [2:0] acc;
        int n;
        resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        fpu_req_ready = 1'b0; fpu_rsp_valid = 1'b0; fpu_rsp_data = '0; fpu_rsp_flags = '0;
        fflags_clr = 1'b0;
        step(); step();
        check("reset ctrl", {52'd0, pcpi_wr, pcpi_wait, pcpi_ready, fpu_req_valid, fpu_op, fflags}, 64'd0);
        check("reset data", 64'(pcpi_rd | fpu_a | fpu_b), 64'd0);
        resetn = 1'b1;
        step();

        run_op("fmul", I_FMUL, 32'h4000_0000, 32'h4040_0000, 2'd2, 0, 4, 32'h40C0_0000, 5'b00000,
               32'h40C0_0000, 4);
        check("fmul fflags", 64'(fflags), 64'd0);

        run_op("fadd", I_FADD, 32'h3F80_0000, 32'h3F80_0000, 2'd0, 0, 1, 32'h4000_0000, 5'b00001,
               32'h4000_0000, 1);
        check("fadd fflags", 64'(fflags), FE ? 64'd1 : 64'd0);
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        check("fflags clear", 64'(fflags), 64'd0);

        run_op("fsub", I_FSUB, 32'h4000_0000, 32'h3F80_0000, 2'd1, 0, 2, 32'h3F80_0000, 5'b00000,
               32'h3F80_0000, 2);

        // non-FP and non-single-precision encodings must be ignored
        acc = '0;
        pcpi_valid = 1'b1; pcpi_insn = I_MUL;
        for (int i = 0; i < 20; i++) begin
            acc |= {pcpi_wait, pcpi_ready, fpu_req_valid};
            step();
        end
        check("mul ignored", 64'(acc), 64'd0);
        acc = '0;
        pcpi_insn = I_FADDD;
        for (int i = 0; i < 8; i++) begin
            acc |= {pcpi_wait, pcpi_ready, fpu_req_valid};
            step();
        end
        check("fadd.d ignored", 64'(acc), 64'd0);
        pcpi_valid = 1'b0;
        step();

        run_op("stall", I_FMUL, 32'h4080_0000, 32'h4000_0000, 2'd2, 5, 3, 32'h4100_0000, 5'b00000,
               32'h4100_0000, 3);

        run_op("timeout", I_FMUL, 32'h4000_0000, 32'h4000_0000, 2'd2, 0, 0, 32'h1234_5678, 5'b00000,
               32'h7FC0_0000, TO);
        check("timeout fflags", 64'(fflags), FE ? 64'h10 : 64'd0);
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        check("timeout fflags clr", 64'(fflags), 64'd0);

        // abort in WAIT: response arriving during drain is discarded
        enter_wait("abort");
        step();
        pcpi_valid = 1'b0;
        acc = '0;
        fpu_rsp_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            fpu_rsp_valid = (i == 2);
            acc[0] |= pcpi_ready;
            acc[1] |= pcpi_wr;
            step();
        end
        fpu_rsp_valid = 1'b0;
        check("abort no ready", 64'(acc), 64'd0);
        run_op("post-abort", I_FMUL, 32'h4040_0000, 32'h4040_0000, 2'd2, 0, 2, 32'h4110_0000, 5'b00000,
               32'h4110_0000, 2);

        // async reset mid-WAIT
        enter_wait("rst");
        step();
        check("rst in wait", 64'(pcpi_wait), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst ctrl", {52'd0, pcpi_wr, pcpi_wait, pcpi_ready, fpu_req_valid, fpu_op, fflags}, 64'd0);
        check("rst data", 64'(pcpi_rd | fpu_a | fpu_b), 64'd0);
        pcpi_valid = 1'b0;
        step();
        resetn = 1'b1;
        step();
        n = 0;
        run_op("post-rst", I_FADD, 32'h4000_0000, 32'h4000_0000, 2'd0, 1, 1, 32'h4080_0000, 5'b00000,
               32'h4080_0000, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
